// File: rtl/ram_arb_if.sv
// Requester-side bus of the RAM arbiter: packed per-requester request
// fields in, one-hot grant/response and shared read data out.
interface ram_arb_if #(
  parameter int NUM_M     = 4,
  parameter int dat_width = 32,
  parameter int adr_width = 32
);
  logic [NUM_M-1:0]           m_req_i;
  logic [NUM_M-1:0]           m_we_i;
  logic [NUM_M-1:0]           m_lock_i;
  logic [NUM_M*adr_width-1:0] m_addr_i;
  logic [NUM_M*dat_width-1:0] m_wdata_i;
  logic [NUM_M-1:0]           m_ack_o;
  logic [NUM_M-1:0]           m_resp_o;
  logic [dat_width-1:0]       m_rdata_o;

  modport master (
    output m_req_i, m_we_i, m_lock_i, m_addr_i, m_wdata_i,
    input  m_ack_o, m_resp_o, m_rdata_o
  );

  modport slave (
    input  m_req_i, m_we_i, m_lock_i, m_addr_i, m_wdata_i,
    output m_ack_o, m_resp_o, m_rdata_o
  );
endinterface

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one synchronous RAM port among NUM_M
// requesters, with a lock for atomic read-modify-write sequences.
module ram_arb #(
  parameter int NUM_M         = 4,
  parameter int dat_width     = 32,
  parameter int adr_width     = 32,
  parameter int ram_adr_width = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  ram_arb_if.slave                 bus,
  output logic [ram_adr_width-1:0] ram_adr_o,
  output logic                     ram_we_o,
  output logic [dat_width-1:0]     ram_dat_o,
  input  logic [dat_width-1:0]     ram_dat_i
);

  localparam int IDX_W   = $clog2(NUM_M);
  localparam int BYTE_SH = $clog2(dat_width / 8);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_M-1:0]   resp_q, resp_d;

  logic               found;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_M-1:0]   ack_vec;
  logic [adr_width-1:0] sel_addr;
  logic [adr_width-1:0] word_addr;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    return IDX_W'((32'(k) + 32'd1) % NUM_M);
  endfunction

  // Grant selection: owner only while locked, otherwise cyclic search from rr_ptr.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == LOCKED) begin
      found   = bus.m_req_i[owner_q];
      gnt_idx = owner_q;
    end else begin
      for (int unsigned i = 0; i < NUM_M; i++) begin
        cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_M);
        if (!found && bus.m_req_i[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    gnt_vld = found && !rst;
    ack_vec = gnt_vld ? (NUM_M'(1) << gnt_idx) : '0;
  end

  // RAM port drive: selected requester's word address and write data, zero when idle.
  always_comb begin
    sel_addr  = bus.m_addr_i[gnt_idx*adr_width +: adr_width];
    word_addr = sel_addr >> BYTE_SH;
    ram_adr_o = gnt_vld ? ram_adr_width'(word_addr) : '0;
    ram_we_o  = gnt_vld && bus.m_we_i[gnt_idx];
    ram_dat_o = ram_we_o ? bus.m_wdata_i[gnt_idx*dat_width +: dat_width] : '0;
  end

  // Next-state: pointer advance, lock entry/release, read-response strobe.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    resp_d   = (gnt_vld && !bus.m_we_i[gnt_idx]) ? ack_vec : '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          rr_ptr_d = next_idx(gnt_idx);
          if (bus.m_lock_i[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
      end
      LOCKED: begin
        // Pointer only moves on the releasing grant; an abandoned lock leaves it alone.
        if (gnt_vld) begin
          if (!bus.m_lock_i[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(owner_q);
          end
        end else if (!bus.m_req_i[owner_q] && !bus.m_lock_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      resp_q   <= resp_d;
    end
  end

  assign bus.m_ack_o   = ack_vec;
  assign bus.m_resp_o  = resp_q;
  assign bus.m_rdata_o = ram_dat_i;

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb with a small registered-read RAM model.
module tb_ram_arb;

  logic        clk;
  logic        rst;
  logic [31:0] ram_adr;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;
  logic [31:0] mem [0:63];

  int n_chk;
  int n_pass;

  ram_arb_if #(.NUM_M(4), .dat_width(32), .adr_width(32)) bus ();

  ram_arb #(
    .NUM_M(4), .dat_width(32), .adr_width(32), .ram_adr_width(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_adr_o (ram_adr),
    .ram_we_o  (ram_we),
    .ram_dat_o (ram_wd),
    .ram_dat_i (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM returning old contents on a same-address write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_adr[5:0]] <= ram_wd;
    ram_rd <= mem[ram_adr[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic drive(input int k, input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.m_req_i[k]              = req;
    bus.m_we_i[k]               = we;
    bus.m_lock_i[k]             = lock;
    bus.m_addr_i[k*32 +: 32]    = addr;
    bus.m_wdata_i[k*32 +: 32]   = wd;
  endtask

  task automatic clear_all();
    bus.m_req_i   = '0;
    bus.m_we_i    = '0;
    bus.m_lock_i  = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst = 1'b1;
    clear_all();

    // Reset: ack and write enable forced low even with requests pending.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    #1;
    check("rst_ack", 32'(bus.m_ack_o), 32'h0);
    check("rst_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    check("rst_resp", 32'(bus.m_resp_o), 32'h0);
    clear_all();

    // Single read by requester 2 at byte 0x10 -> word 4.
    rst = 1'b0;
    drive(2, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    check("rd_ack", 32'(bus.m_ack_o), 32'h4);
    check("rd_adr", ram_adr, 32'h4);
    check("rd_we", 32'(ram_we), 32'h0);
    check("rd_dat_o", ram_wd, 32'h0);
    @(negedge clk);
    check("rd_resp", 32'(bus.m_resp_o), 32'h4);
    check("rd_data", bus.m_rdata_o, 32'hA000_0004);
    clear_all();
    #1;
    check("idle_ack", 32'(bus.m_ack_o), 32'h0);
    check("idle_adr", ram_adr, 32'h0);
    @(negedge clk);
    check("idle_resp", 32'(bus.m_resp_o), 32'h0);

    // Round-robin from reset with all four reading continuously.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) drive(k, 1'b1, 1'b0, 1'b0, 32'(k * 4), 32'h0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        check("rr_resp", 32'(bus.m_resp_o), 32'(1) << ((c - 1) % 4));
        check("rr_data", bus.m_rdata_o, 32'hA000_0000 + 32'((c - 1) % 4));
      end
      #1;
      check("rr_ack", 32'(bus.m_ack_o), 32'(1) << (c % 4));
      @(negedge clk);
    end
    clear_all();
    check("rr_resp_last", 32'(bus.m_resp_o), 32'h8);
    check("rr_data_last", bus.m_rdata_o, 32'hA000_0003);

    // Write 0xDEADBEEF to byte 0x20 then read it back (rr_ptr=0).
    drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF);
    #1;
    check("wr_ack", 32'(bus.m_ack_o), 32'h1);
    check("wr_we", 32'(ram_we), 32'h1);
    check("wr_adr", ram_adr, 32'h8);
    check("wr_dat", ram_wd, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr_resp", 32'(bus.m_resp_o), 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hDEAD_BEEF);
    #1;
    check("wrrd_ack", 32'(bus.m_ack_o), 32'h1);
    check("wrrd_we", 32'(ram_we), 32'h0);
    check("wrrd_dat_o", ram_wd, 32'h0);
    @(negedge clk);
    check("wrrd_resp", 32'(bus.m_resp_o), 32'h1);
    check("wrrd_data", bus.m_rdata_o, 32'hDEAD_BEEF);
    clear_all();

    // Lock: requester 1 read-modify-write of 0x8 while 0 and 3 wait (rr_ptr=1).
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
    drive(3, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
    #1;
    check("lk_ack1", 32'(bus.m_ack_o), 32'h2);
    @(negedge clk);
    check("lk_resp1", 32'(bus.m_resp_o), 32'h2);
    check("lk_data1", bus.m_rdata_o, 32'hA000_0002);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h1234_5678);
    #1;
    check("lk_ack2", 32'(bus.m_ack_o), 32'h2);
    check("lk_we2", 32'(ram_we), 32'h1);
    @(negedge clk);
    check("lk_resp2", 32'(bus.m_resp_o), 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("lk_ack3", 32'(bus.m_ack_o), 32'h8);
    @(negedge clk);
    check("lk_resp3", 32'(bus.m_resp_o), 32'h8);
    check("lk_data3", bus.m_rdata_o, 32'hA000_0003);
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("lk_ack4", 32'(bus.m_ack_o), 32'h1);
    @(negedge clk);
    check("lk_resp4", 32'(bus.m_resp_o), 32'h1);
    check("lk_data4", bus.m_rdata_o, 32'hA000_0000);
    clear_all();

    // Lock abandon: requester 2 locks (rr_ptr=1), then drops req and lock.
    drive(2, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
    #1;
    check("ab_ack1", 32'(bus.m_ack_o), 32'h4);
    @(negedge clk);
    check("ab_resp1", 32'(bus.m_resp_o), 32'h4);
    check("ab_data1", bus.m_rdata_o, 32'h1234_5678);
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    check("ab_ack2", 32'(bus.m_ack_o), 32'h0);
    @(negedge clk);
    check("ab_resp2", 32'(bus.m_resp_o), 32'h0);
    #1;
    check("ab_ack3", 32'(bus.m_ack_o), 32'h1);
    @(negedge clk);
    check("ab_resp3", 32'(bus.m_resp_o), 32'h1);
    check("ab_data3", bus.m_rdata_o, 32'hDEAD_BEEF);
    clear_all();

    // Reset mid-read: requester 3 acked, reset taken at the closing edge.
    drive(3, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
    #1;
    check("mr_ack", 32'(bus.m_ack_o), 32'h8);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mr_resp", 32'(bus.m_resp_o), 32'h0);
    clear_all();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    check("mr_ptr_ack1", 32'(bus.m_ack_o), 32'h1);
    @(negedge clk);
    check("mr_resp1", 32'(bus.m_resp_o), 32'h1);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("mr_ptr_ack2", 32'(bus.m_ack_o), 32'h4);
    @(negedge clk);
    check("mr_resp2", 32'(bus.m_resp_o), 32'h4);
    check("mr_data2", bus.m_rdata_o, 32'hA000_0004);
    clear_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
# ram_arb

Round-robin arbiter that shares one port of the dual-port synchronous RAM among NUM_M requesters: a core's fetch and load/store units, a debug loader, and DMA. Each cycle it selects at most one requester and drives the RAM port (address, write enable, write data). One cycle later it routes the RAM's registered read data back, marked with a one-hot response strobe. It also supports a lock, so one requester can keep the port for an atomic read-modify-write.

## Interface
Parameters:
- NUM_M, 4, number of requesters (2..8)
- dat_width, 32, data width in bits (multiple of 8)
- adr_width, 32, requester byte-address width
- ram_adr_width, 32, RAM word-address width

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- m_req_i  in  NUM_M  request valid, bit k = requester k
- m_we_i  in  NUM_M  1 = write, 0 = read
- m_lock_i  in  NUM_M  keep ownership after this access
- m_addr_i  in  NUM_M*adr_width  byte address; slice k = [k*adr_width +: adr_width]
- m_wdata_i  in  NUM_M*dat_width  write data, sliced the same way
- m_ack_o  out  NUM_M  one-hot grant; access is issued to the RAM this cycle
- m_resp_o  out  NUM_M  one-hot read-data-valid, registered
- m_rdata_o  out  dat_width  read data; valid for requester k when m_resp_o[k]=1
- ram_adr_o  out  ram_adr_width  RAM word address
- ram_we_o  out  1  RAM write enable
- ram_dat_o  out  dat_width  RAM write data
- ram_dat_i  in  dat_width  RAM registered read data (port dat_o)

## Operation
- Word address: ram_adr_o = m_addr_i[k] >> log2(dat_width/8), zero-extended or truncated to ram_adr_width. Low byte-offset bits are ignored; there are no byte enables.
- Arbitration state: rr_ptr (index, reset 0), fsm state IDLE/LOCKED (reset IDLE), owner index (reset 0).
- IDLE:
  - Grant the first requester with m_req_i set, searching cyclically rr_ptr, rr_ptr+1, …, NUM_M-1, 0, ….
  - After granting k, set rr_ptr = (k+1) mod NUM_M.
  - If m_lock_i[k]=1 at the grant, go to LOCKED with owner=k.
- LOCKED:
  - Only the owner can be granted; other requests wait (ack=0).
  - Owner granted with m_lock_i=1: stay LOCKED.
  - Owner granted with m_lock_i=0: go to IDLE (this access completes normally).
  - Owner with m_req_i=0 and m_lock_i=0: go to IDLE with no grant.
  - rr_ptr is unchanged while LOCKED, except the releasing grant, which sets rr_ptr = owner+1.
- m_ack_o is combinational from the current requests and the registered state. At most one bit is set. The granted request is consumed in that cycle. A requester keeps req/we/addr/wdata stable until it sees ack.
- With no grant: ram_we_o=0, ram_adr_o=0, ram_dat_o=0.
- With a grant to k: ram_we_o=m_we_i[k], ram_dat_o = slice k of m_wdata_i (driven to 0 when reading).
- Responses: a read granted in cycle t sets m_resp_o[k]=1 in cycle t+1 only. Writes produce no response. m_rdata_o = ram_dat_i, passed through unregistered and undefined when m_resp_o=0.
- The RAM returns the old contents on a same-address write, so a write never returns data. A read in cycle t+1 after a write in cycle t to the same address returns the new data.

## Timing
- Grant latency: 0 cycles, combinational ack in the request cycle when the port is free.
- Read latency: ack in cycle t, m_resp_o and m_rdata_o in cycle t+1.
- Throughput: one access per cycle, reads and writes back-to-back, with no bubbles.
- Reset (rst=1 at posedge):
  - rr_ptr=0, state=IDLE, owner=0, m_resp_o=0.
  - m_ack_o=0 and ram_we_o=0 combinationally while rst=1.
  - A read granted the cycle before reset gets no response.
- Fairness: with all NUM_M requesting continuously and no locks, each requester is granted once every NUM_M cycles.
- A request deasserted before ack is dropped silently. Lock asserted without req has no effect in IDLE.

## Test plan
- Reset then single read: requester 2 reads byte addr 0x10 → ack[2] in the request cycle, ram_adr_o=4, m_resp_o=0100 next cycle, m_rdata_o = contents of word 4.
- Round-robin: all 4 request reads continuously from reset → ack sequence 0,1,2,3,0,…; each resp exactly 1 cycle after its ack.
- Write then read: requester 0 writes 0xDEADBEEF to 0x20, then reads 0x20 → ram_we_o=1 for one cycle, no resp for the write, read returns 0xDEADBEEF.
- Lock: requester 1 reads 0x8 with lock=1, then writes 0x8 with lock=0, while requesters 0 and 3 are requesting → both grants go to 1; next grant goes to 3 (rr_ptr=2 search, 2 idle).
- Lock abandon: the owner drops req and lock → IDLE next cycle; waiting requester 0 is granted.
- Reset mid-read: ack[3] for a read in cycle t, rst=1 at that edge → m_resp_o=0 in t+1; rr_ptr=0 afterwards.
